// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and micro-op encodings for the ID stage.
package riscv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] MULDIV  = 7'b0000001;

  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP    = 8'h00;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP    = 8'h02;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP    = 8'h03;
  localparam logic [ALUOP_W-1:0] EXE_MUL_OP    = 8'h18;
  localparam logic [ALUOP_W-1:0] EXE_MULH_OP   = 8'h19;
  localparam logic [ALUOP_W-1:0] EXE_MULHSU_OP = 8'h1A;
  localparam logic [ALUOP_W-1:0] EXE_MULHU_OP  = 8'h1B;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP    = 8'h20;
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP    = 8'h22;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP    = 8'h24;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP     = 8'h25;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP    = 8'h26;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP    = 8'h2A;
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP   = 8'h2B;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP    = 8'h7C;

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'd0;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'd1;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'd2;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'd3;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MUL   = 3'd4;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_SH,
    IMM_U
  } imm_sel_e;

  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic                use1;
    logic                use2;
    logic                use_pc;
    logic                wreg;
    logic                illegal;
    imm_sel_e            imm_sel;
  } dec_t;

  function automatic logic [ALUSEL_W-1:0] res_class(input logic [ALUOP_W-1:0] op);
    case (op)
      EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP:                 return EXE_RES_LOGIC;
      EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:                return EXE_RES_SHIFT;
      EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP, EXE_SLTU_OP:   return EXE_RES_ARITH;
      EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP,
      EXE_MULHU_OP:                                      return EXE_RES_MUL;
      default:                                           return EXE_RES_NOP;
    endcase
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand: youngest matching bypass entry wins, else register file.
// pend_o flags that the winning entry has no result yet (load in flight).
module operand_bypass
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]              addr_i,
  input  logic                    use_i,
  input  logic [XLEN-1:0]         rf_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [NUM_FWD*5-1:0]    fwd_wd_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_pend_i,
  output logic [XLEN-1:0]         data_o,
  output logic                    pend_o
);

  always_comb begin
    data_o = '0;
    pend_o = 1'b0;
    if (use_i && addr_i != NOP_REG_ADDR) begin
      data_o = rf_data_i;
      // Walk oldest to youngest so the lowest matching index is the final winner.
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_wreg_i[k] && fwd_wd_i[k*5 +: 5] == addr_i) begin
          data_o = fwd_wdata_i[k*XLEN +: XLEN];
          pend_o = fwd_pend_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I/RV64I OP/OP-IMM/LUI/AUIPC + RV32M MUL decode stage, 1-cycle latency,
// valid/ready toward EX, load-use stall with saturating counter, flush drops held and incoming ops.
module id_stage_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [31:0]             inst_i,
  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  input  logic [XLEN-1:0]         rs1_data_i,
  input  logic [XLEN-1:0]         rs2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [NUM_FWD*5-1:0]    fwd_wd_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_pend_i,
  input  logic                    flush_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ALUOP_W-1:0]      aluop_o,
  output logic [ALUSEL_W-1:0]     alusel_o,
  output logic [XLEN-1:0]         reg1_o,
  output logic [XLEN-1:0]         reg2_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic [XLEN-1:0]         pc_o,
  output logic                    illegal_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [6:0] sh_f7;
  dec_t       dec;

  assign opcode     = inst_i[6:0];
  assign funct3     = inst_i[14:12];
  assign funct7     = inst_i[31:25];
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];
  // On RV64 bit 25 belongs to the 6-bit shamt, so it is excluded from the funct check.
  assign sh_f7 = (XLEN == 64) ? {inst_i[31:26], 1'b0} : inst_i[31:25];

  always_comb begin
    dec         = '0;
    dec.aluop   = EXE_NOP_OP;
    dec.imm_sel = IMM_I;
    case (opcode)
      OP_IMM: begin
        dec.use1 = 1'b1;
        case (funct3)
          F3_ADD:  dec.aluop = EXE_ADD_OP;
          F3_SLT:  dec.aluop = EXE_SLT_OP;
          F3_SLTU: dec.aluop = EXE_SLTU_OP;
          F3_XOR:  dec.aluop = EXE_XOR_OP;
          F3_OR:   dec.aluop = EXE_OR_OP;
          F3_AND:  dec.aluop = EXE_AND_OP;
          F3_SLL: begin
            dec.imm_sel = IMM_SH;
            if (sh_f7 == F7_BASE) dec.aluop = EXE_SLL_OP;
          end
          F3_SR: begin
            dec.imm_sel = IMM_SH;
            if (sh_f7 == F7_BASE)     dec.aluop = EXE_SRL_OP;
            else if (sh_f7 == F7_ALT) dec.aluop = EXE_SRA_OP;
          end
          default: ;
        endcase
      end
      OP: begin
        dec.use1 = 1'b1;
        dec.use2 = 1'b1;
        case (funct7)
          F7_BASE: begin
            case (funct3)
              F3_ADD:  dec.aluop = EXE_ADD_OP;
              F3_SLL:  dec.aluop = EXE_SLL_OP;
              F3_SLT:  dec.aluop = EXE_SLT_OP;
              F3_SLTU: dec.aluop = EXE_SLTU_OP;
              F3_XOR:  dec.aluop = EXE_XOR_OP;
              F3_SR:   dec.aluop = EXE_SRL_OP;
              F3_OR:   dec.aluop = EXE_OR_OP;
              default: dec.aluop = EXE_AND_OP;
            endcase
          end
          F7_ALT: begin
            if (funct3 == F3_ADD)     dec.aluop = EXE_SUB_OP;
            else if (funct3 == F3_SR) dec.aluop = EXE_SRA_OP;
          end
          MULDIV: begin
            case (funct3)
              F3_MUL:    dec.aluop = EXE_MUL_OP;
              F3_MULH:   dec.aluop = EXE_MULH_OP;
              F3_MULHSU: dec.aluop = EXE_MULHSU_OP;
              F3_MULHU:  dec.aluop = EXE_MULHU_OP;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      LUI: begin
        dec.aluop   = EXE_ADD_OP;
        dec.imm_sel = IMM_U;
      end
      AUIPC: begin
        dec.aluop   = EXE_ADD_OP;
        dec.imm_sel = IMM_U;
        dec.use_pc  = 1'b1;
      end
      default: ;
    endcase
    // Every legal encoding above lands on a real operation, so NOP means unsupported.
    dec.illegal = (dec.aluop == EXE_NOP_OP);
    dec.wreg    = !dec.illegal;
    dec.alusel  = res_class(dec.aluop);
  end

  logic [XLEN-1:0] imm;
  always_comb begin
    case (dec.imm_sel)
      IMM_SH:  imm = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
      IMM_U:   imm = XLEN'($signed({inst_i[31:12], 12'b0}));
      default: imm = XLEN'($signed(inst_i[31:20]));
    endcase
  end

  logic [XLEN-1:0] op1, op2;
  logic            pend1, pend2, hazard, accept;

  operand_bypass #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_byp_rs1 (
    .addr_i      (rs1_addr_o),
    .use_i       (dec.use1),
    .rf_data_i   (rs1_data_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .fwd_pend_i  (fwd_pend_i),
    .data_o      (op1),
    .pend_o      (pend1)
  );

  operand_bypass #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_byp_rs2 (
    .addr_i      (rs2_addr_o),
    .use_i       (dec.use2),
    .rf_data_i   (rs2_data_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .fwd_pend_i  (fwd_pend_i),
    .data_o      (op2),
    .pend_o      (pend2)
  );

  logic                out_valid_q, out_valid_d;
  logic [ALUOP_W-1:0]  aluop_q, aluop_d;
  logic [ALUSEL_W-1:0] alusel_q, alusel_d;
  logic [XLEN-1:0]     reg1_q, reg1_d, reg2_q, reg2_d, pc_q, pc_d;
  logic [4:0]          wd_q, wd_d;
  logic                wreg_q, wreg_d, illegal_q, illegal_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  assign hazard   = pend1 | pend2;
  assign in_ready = !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush_i;

  always_comb begin
    out_valid_d = out_valid_q;
    aluop_d     = aluop_q;
    alusel_d    = alusel_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    pc_d        = pc_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    illegal_d   = illegal_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      aluop_d     = dec.aluop;
      alusel_d    = dec.alusel;
      reg1_d      = dec.use1 ? op1 : (dec.use_pc ? pc_i : '0);
      reg2_d      = dec.use2 ? op2 : imm;
      pc_d        = pc_i;
      wd_d        = inst_i[11:7];
      wreg_d      = dec.wreg;
      illegal_d   = dec.illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (in_valid && hazard && !flush_i && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      aluop_q     <= EXE_NOP_OP;
      alusel_q    <= EXE_RES_NOP;
      reg1_q      <= '0;
      reg2_q      <= '0;
      pc_q        <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      aluop_q     <= aluop_d;
      alusel_q    <= alusel_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      pc_q        <= pc_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign aluop_o     = aluop_q;
  assign alusel_o    = alusel_q;
  assign reg1_o      = reg1_q;
  assign reg2_o      = reg2_q;
  assign pc_o        = pc_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign illegal_o   = illegal_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a default 32-bit instance and a 64-bit, 4-bit-counter instance.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, flush, out_valid, out_ready, wreg, illegal;
  logic [31:0] pc, inst, rf1, rf2, reg1, reg2, pc_out;
  logic [4:0]  rs1a, rs2a, wd;
  logic [1:0]  fwd_wreg, fwd_pend;
  logic [9:0]  fwd_wd;
  logic [63:0] fwd_wdata;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [15:0] stall_cnt;

  id_stage_pipe #(.XLEN(32), .NUM_FWD(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc), .inst_i(inst),
    .rs1_addr_o(rs1a), .rs2_addr_o(rs2a), .rs1_data_i(rf1), .rs2_data_i(rf2),
    .fwd_wreg_i(fwd_wreg), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata), .fwd_pend_i(fwd_pend),
    .flush_i(flush), .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop),
    .alusel_o(alusel), .reg1_o(reg1), .reg2_o(reg2), .wd_o(wd), .wreg_o(wreg), .pc_o(pc_out),
    .illegal_o(illegal), .stall_cnt_o(stall_cnt)
  );

  // 64-bit instance with a narrow stall counter
  logic         in_valid64, in_ready64, out_valid64, wreg64, illegal64;
  logic [63:0]  pc64, rf1_64, rf2_64, reg1_64, reg2_64, pc_out64;
  logic [31:0]  inst64;
  logic [4:0]   rs1a64, rs2a64, wd64;
  logic [1:0]   fwd_wreg64, fwd_pend64;
  logic [9:0]   fwd_wd64;
  logic [127:0] fwd_wdata64;
  logic [7:0]   aluop64;
  logic [2:0]   alusel64;
  logic [3:0]   stall_cnt64;

  id_stage_pipe #(.XLEN(64), .NUM_FWD(2), .CNT_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .pc_i(pc64), .inst_i(inst64),
    .rs1_addr_o(rs1a64), .rs2_addr_o(rs2a64), .rs1_data_i(rf1_64), .rs2_data_i(rf2_64),
    .fwd_wreg_i(fwd_wreg64), .fwd_wd_i(fwd_wd64), .fwd_wdata_i(fwd_wdata64), .fwd_pend_i(fwd_pend64),
    .flush_i(1'b0), .out_valid(out_valid64), .out_ready(1'b1), .aluop_o(aluop64),
    .alusel_o(alusel64), .reg1_o(reg1_64), .reg2_o(reg2_64), .wd_o(wd64), .wreg_o(wreg64),
    .pc_o(pc_out64), .illegal_o(illegal64), .stall_cnt_o(stall_cnt64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    fwd_wreg  = 2'b00;
    fwd_pend  = 2'b00;
    fwd_wd    = '0;
    fwd_wdata = '0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  aluop;
    logic [2:0]  sel;
    logic        ill;
    logic [31:0] r1;
    logic [31:0] r2;
  } vec_t;

  vec_t tv [11];

  initial begin
    rst = 1'b1;
    idle32();
    pc = 32'h0; inst = 32'h0; rf1 = 32'h0; rf2 = 32'h0;
    in_valid64 = 1'b0; pc64 = '0; inst64 = '0; rf1_64 = '0; rf2_64 = '0;
    fwd_wreg64 = '0; fwd_pend64 = '0; fwd_wd64 = '0; fwd_wdata64 = '0;

    tv[0]  = '{32'h40001033, 8'h00, 3'd0, 1'b1, 32'h0, 32'h0};
    tv[1]  = '{32'h402081B3, 8'h22, 3'd3, 1'b0, 32'h7, 32'h3};
    tv[2]  = '{32'h4020D1B3, 8'h03, 3'd2, 1'b0, 32'h7, 32'h3};
    tv[3]  = '{32'h0220B1B3, 8'h1B, 3'd4, 1'b0, 32'h7, 32'h3};
    tv[4]  = '{32'h0220C1B3, 8'h00, 3'd0, 1'b1, 32'h0, 32'h0};
    tv[5]  = '{32'h123452B7, 8'h20, 3'd3, 1'b0, 32'h0, 32'h12345000};
    tv[6]  = '{32'h80000297, 8'h20, 3'd3, 1'b0, 32'h300, 32'h80000000};
    tv[7]  = '{32'h4040D193, 8'h03, 3'd2, 1'b0, 32'h7, 32'h4};
    tv[8]  = '{32'hFFF00093, 8'h20, 3'd3, 1'b0, 32'h0, 32'hFFFFFFFF};
    tv[9]  = '{32'h02809093, 8'h00, 3'd0, 1'b1, 32'h0, 32'h0};
    tv[10] = '{32'h00000000, 8'h00, 3'd0, 1'b1, 32'h0, 32'h0};

    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("rst_aluop", 64'(aluop), 64'h0);
    check_eq("rst_alusel", 64'(alusel), 64'h0);
    check_eq("rst_reg2", 64'(reg2), 64'h0);
    check_eq("rst_wreg", 64'(wreg), 64'h0);
    check_eq("rst_stall", 64'(stall_cnt), 64'h0);
    check_eq("rst_in_ready", 64'(in_ready), 64'h1);
    tick();

    // addi x1,x0,5
    in_valid = 1'b1; inst = 32'h00500093; pc = 32'h100; rf1 = 32'h1234;
    @(negedge clk);
    check_eq("addi_in_ready", 64'(in_ready), 64'h1);
    check_eq("addi_rs1_addr", 64'(rs1a), 64'h0);
    tick();
    in_valid = 1'b0;
    check_eq("addi_valid", 64'(out_valid), 64'h1);
    check_eq("addi_aluop", 64'(aluop), 64'h20);
    check_eq("addi_alusel", 64'(alusel), 64'h3);
    check_eq("addi_reg1", 64'(reg1), 64'h0);
    check_eq("addi_reg2", 64'(reg2), 64'h5);
    check_eq("addi_wd", 64'(wd), 64'h1);
    check_eq("addi_wreg", 64'(wreg), 64'h1);
    check_eq("addi_pc", 64'(pc_out), 64'h100);
    tick();
    check_eq("bubble_valid", 64'(out_valid), 64'h0);

    // add x3,x1,x2 with both bypass entries targeting x1
    in_valid = 1'b1; inst = 32'h002081B3; pc = 32'h104; rf1 = 32'h1111; rf2 = 32'h2222;
    fwd_wreg = 2'b11; fwd_wd = {5'd1, 5'd1}; fwd_wdata = {32'h0000BBBB, 32'h0000AAAA};
    @(negedge clk);
    check_eq("add_rs1_addr", 64'(rs1a), 64'h1);
    check_eq("add_rs2_addr", 64'(rs2a), 64'h2);
    tick();
    check_eq("fwd_ex_reg1", 64'(reg1), 64'hAAAA);
    check_eq("fwd_ex_reg2", 64'(reg2), 64'h2222);
    fwd_wreg = 2'b10;
    tick();
    check_eq("fwd_mem_reg1", 64'(reg1), 64'hBBBB);
    fwd_wreg = 2'b00;
    tick();
    check_eq("fwd_rf_reg1", 64'(reg1), 64'h1111);
    inst = 32'h002001B3; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd0};
    tick();
    check_eq("x0_reg1", 64'(reg1), 64'h0);
    check_eq("x0_reg2", 64'(reg2), 64'h2222);
    idle32();
    tick();

    // load-use stall on x1 for two cycles
    in_valid = 1'b1; inst = 32'h002081B3; pc = 32'h108;
    fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd1}; fwd_pend = 2'b01; fwd_wdata = {32'h0, 32'h00005555};
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check_eq("stall_in_ready", 64'(in_ready), 64'h0);
      tick();
      check_eq("stall_bubble", 64'(out_valid), 64'h0);
      check_eq("stall_cnt", 64'(stall_cnt), 64'(c));
    end
    fwd_pend = 2'b00;
    @(negedge clk);
    check_eq("unstall_in_ready", 64'(in_ready), 64'h1);
    tick();
    check_eq("unstall_valid", 64'(out_valid), 64'h1);
    check_eq("unstall_reg1", 64'(reg1), 64'h5555);
    check_eq("unstall_cnt", 64'(stall_cnt), 64'h2);

    // backpressure
    idle32();
    in_valid = 1'b1; inst = 32'h00500093; pc = 32'h200;
    tick();
    check_eq("bp_first_valid", 64'(out_valid), 64'h1);
    inst = 32'h00F06113; pc = 32'h204; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 64'(in_ready), 64'h0);
      tick();
      check_eq("bp_hold_valid", 64'(out_valid), 64'h1);
      check_eq("bp_hold_pc", 64'(pc_out), 64'h200);
      check_eq("bp_hold_reg2", 64'(reg2), 64'h5);
      check_eq("bp_hold_wd", 64'(wd), 64'h1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", 64'(in_ready), 64'h1);
    tick();
    check_eq("ori_valid", 64'(out_valid), 64'h1);
    check_eq("ori_aluop", 64'(aluop), 64'h25);
    check_eq("ori_alusel", 64'(alusel), 64'h1);
    check_eq("ori_reg2", 64'(reg2), 64'hF);
    check_eq("ori_wd", 64'(wd), 64'h2);
    check_eq("ori_pc", 64'(pc_out), 64'h204);

    // flush while holding, with a hazardous incoming instruction
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check_eq("pre_flush_hold", 64'(out_valid), 64'h1);
    flush = 1'b1; in_valid = 1'b1; inst = 32'h002081B3;
    fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd1}; fwd_pend = 2'b01;
    tick();
    check_eq("flush_valid", 64'(out_valid), 64'h0);
    check_eq("flush_no_stall", 64'(stall_cnt), 64'h2);
    idle32();
    tick();
    check_eq("flush_dropped", 64'(out_valid), 64'h0);

    // decode table
    rf1 = 32'h7; rf2 = 32'h3; pc = 32'h300; in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      inst = tv[i].inst;
      tick();
      check_eq($sformatf("tv%0d_valid", i), 64'(out_valid), 64'h1);
      check_eq($sformatf("tv%0d_illegal", i), 64'(illegal), 64'(tv[i].ill));
      check_eq($sformatf("tv%0d_wreg", i), 64'(wreg), 64'(!tv[i].ill));
      check_eq($sformatf("tv%0d_aluop", i), 64'(aluop), 64'(tv[i].aluop));
      check_eq($sformatf("tv%0d_alusel", i), 64'(alusel), 64'(tv[i].sel));
      if (!tv[i].ill) begin
        check_eq($sformatf("tv%0d_reg1", i), 64'(reg1), 64'(tv[i].r1));
        check_eq($sformatf("tv%0d_reg2", i), 64'(reg2), 64'(tv[i].r2));
      end
    end

    // reset mid-operation
    inst = 32'h00500093;
    tick();
    check_eq("pre_rst_valid", 64'(out_valid), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", 64'(out_valid), 64'h0);
    check_eq("mid_rst_stall", 64'(stall_cnt), 64'h0);
    check_eq("mid_rst_aluop", 64'(aluop), 64'h0);
    check_eq("mid_rst_reg2", 64'(reg2), 64'h0);
    check_eq("mid_rst_pc", 64'(pc_out), 64'h0);
    idle32();

    // 64-bit instance
    in_valid64 = 1'b1; rf1_64 = 64'h1; pc64 = 64'h1000;
    inst64 = 32'h02809093;
    tick();
    check_eq("rv64_slli_valid", 64'(out_valid64), 64'h1);
    check_eq("rv64_slli_aluop", 64'(aluop64), 64'h7C);
    check_eq("rv64_slli_illegal", 64'(illegal64), 64'h0);
    check_eq("rv64_slli_reg2", reg2_64, 64'd40);
    inst64 = 32'h4210D193;
    tick();
    check_eq("rv64_srai_aluop", 64'(aluop64), 64'h03);
    check_eq("rv64_srai_reg2", reg2_64, 64'd33);
    inst64 = 32'h800002B7;
    tick();
    check_eq("rv64_lui_reg2", reg2_64, 64'hFFFFFFFF80000000);
    inst64 = 32'h002081B3; fwd_wreg64 = 2'b01; fwd_wd64 = {5'd0, 5'd1}; fwd_pend64 = 2'b01;
    for (int c = 0; c < 20; c++) tick();
    check_eq("sat_stall_cnt", 64'(stall_cnt64), 64'hF);
    check_eq("sat_out_valid", 64'(out_valid64), 64'h0);
    in_valid64 = 1'b0; fwd_wreg64 = '0; fwd_pend64 = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
